// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the stream demultiplexer.
package stream_demux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;
    localparam int DROP_MAX  = 255;

    // Routing state: IDLE follows s_sel, LOCKED holds the packet's channel.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register with valid/ready for a single channel.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic             o_can_load,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic             w_can_load;

    // The slot can take a beat when empty or when it drains this same cycle.
    assign w_can_load = !r_valid || i_ready;
    assign o_can_load = w_can_load;
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_last     = r_last;

    // Load has priority over drain so a simultaneous drain/load keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_valid && w_can_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NCH stream demultiplexer with packet-locked routing.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NCH   = DEF_NCH,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    input  logic [SELW-1:0]      s_sel,
    input  logic                 s_last,
    output logic [NCH-1:0]       m_valid,
    input  logic [NCH-1:0]       m_ready,
    output logic [NCH*WIDTH-1:0] m_data,
    output logic [NCH-1:0]       m_last,
    output logic [7:0]           drop_cnt
);

    // Select values span a full power of two; codes at or above NCH are dropped.
    localparam int NSEL = 1 << SELW;

    state_t          r_state;
    state_t          w_state_next;
    logic [SELW-1:0] r_lock_sel;
    logic [SELW-1:0] w_lock_sel_next;
    logic [7:0]      r_drop_cnt;

    logic [SELW-1:0] w_target;
    logic            w_in_range;
    logic            w_tgt_ready;
    logic            w_accept;
    logic [NCH-1:0]  w_can_load;
    logic [NCH-1:0]  w_load;
    logic [NSEL-1:0] w_can_load_ext;

    assign w_target   = (r_state == LOCKED) ? r_lock_sel : s_sel;
    assign w_in_range = ({1'b0, w_target} < (SELW + 1)'(NCH));

    // Pad the per-channel ready vector so every select code indexes a defined bit.
    generate
        for (genvar gi = 0; gi < NSEL; gi++) begin : g_ext
            if (gi < NCH) begin : g_real
                assign w_can_load_ext[gi] = w_can_load[gi];
            end else begin : g_pad
                assign w_can_load_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_tgt_ready = w_can_load_ext[w_target];
    // Out-of-range beats are always taken so they can be discarded.
    assign s_ready     = !rst && (!w_in_range || w_tgt_ready);
    assign w_accept    = s_valid && s_ready;
    assign drop_cnt    = r_drop_cnt;

    // One output slot per channel, loaded only by beats routed to it.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
            assign w_load[gi] = w_accept && w_in_range && (w_target == SELW'(gi));

            stream_demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .i_valid    (w_load[gi]),
                .i_data     (s_data),
                .i_last     (s_last),
                .o_can_load (w_can_load[gi]),
                .o_valid    (m_valid[gi]),
                .o_data     (m_data[gi*WIDTH +: WIDTH]),
                .o_last     (m_last[gi]),
                .i_ready    (m_ready[gi])
            );
        end
    endgenerate

    // Routing state and locked channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock_sel <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_sel <= w_lock_sel_next;
        end
    end

    // Next-state logic: lock on the first beat of a multi-beat packet, unlock on last.
    always_comb begin
        w_state_next    = r_state;
        w_lock_sel_next = r_lock_sel;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (!s_last) begin
                        w_state_next    = LOCKED;
                        w_lock_sel_next = s_sel;
                    end
                end
                LOCKED: begin
                    if (s_last) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Saturating count of beats discarded for an out-of-range target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_in_range && (r_drop_cnt != 8'(DROP_MAX))) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench: stimulus pushes expected beats per channel, a monitor pops on transfer.
module tb_stream_demux;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         acc;
        bit         chk_lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // NCH=4 instance
    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_data;
    logic [1:0]  s_sel;
    logic [3:0]  m_valid, m_ready, m_last;
    logic [31:0] m_data;
    logic [7:0]  drop_cnt;

    // NCH=3 instance
    logic        t_valid, t_ready, t_last;
    logic [7:0]  t_data;
    logic [1:0]  t_sel;
    logic [2:0]  tm_valid, tm_ready, tm_last;
    logic [23:0] tm_data;
    logic [7:0]  t_drop_cnt;

    exp_t        exp_q[4][$];
    bit   [3:0]  prev_hold = '0;
    logic [8:0]  prev_val[4];
    bit          saw_valid3 = 1'b0;

    stream_demux #(.WIDTH(8), .NCH(4)) u_dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sel(s_sel), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .drop_cnt(drop_cnt)
    );

    stream_demux #(.WIDTH(8), .NCH(3)) u_dut3 (
        .clk(clk), .rst(rst), .s_valid(t_valid), .s_ready(t_ready), .s_data(t_data),
        .s_sel(t_sel), .s_last(t_last), .m_valid(tm_valid), .m_ready(tm_ready),
        .m_data(tm_data), .m_last(tm_last), .drop_cnt(t_drop_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: pop and compare on every transfer, and check stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_hold = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (prev_hold[k])
                    chk($sformatf("stable_ch%0d", k),
                        {22'd0, m_valid[k], m_last[k], m_data[k*8 +: 8]}, {22'd0, 1'b1, prev_val[k]});
                if (m_valid[k] && m_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ch%0d: got data 0x%0h with no beat expected", k, m_data[k*8 +: 8]);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("data_ch%0d", k), {24'd0, m_data[k*8 +: 8]}, {24'd0, e.data});
                        chk($sformatf("last_ch%0d", k), {31'd0, m_last[k]}, {31'd0, e.last});
                        if (e.chk_lat)
                            chk($sformatf("latency_ch%0d", k), cyc, e.acc);
                    end
                end
                prev_hold[k] = m_valid[k] && !m_ready[k];
                prev_val[k]  = {m_last[k], m_data[k*8 +: 8]};
            end
        end
        if (!rst && (tm_valid != 3'b000)) saw_valid3 = 1'b1;
    end

    // Drive one beat into the NCH=4 instance; ch<0 means the beat is not expected out.
    task automatic send(input logic [1:0] sel, input logic [7:0] data, input logic last,
                        input int ch, input bit lat);
        exp_t e;
        int   w;
        s_valid = 1'b1;
        s_sel   = sel;
        s_data  = data;
        s_last  = last;
        w       = 0;
        @(negedge clk);
        while (!s_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready 0 for 50 cycles expected 1, data 0x%0h", data);
        end else begin
            if (lat) chk("no_stall", w, 0);
            if (ch >= 0) begin
                e.data    = data;
                e.last    = last;
                e.acc     = cyc + 1;
                e.chk_lat = lat;
                exp_q[ch].push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; s_sel = '0; s_last = 1'b0; m_ready = 4'hF;
        t_valid = 1'b0; t_data = '0; t_sel = '0; t_last = 1'b0; tm_ready = 3'h7;

        // Reset state
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_s_ready", {31'd0, s_ready}, 0);
        chk("rst_s_ready3", {31'd0, t_ready}, 0);
        chk("rst_m_valid", {28'd0, m_valid}, 0);
        chk("rst_m_last", {28'd0, m_last}, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", {31'd0, s_ready}, 1);
        chk("post_rst_s_ready3", {31'd0, t_ready}, 1);
        @(posedge clk);
        #1;

        // Single-beat routing to every channel, back to back
        for (int i = 0; i < 4; i++) send(2'(i), 8'hA0 + 8'(i), 1'b1, i, 1'b1);
        idle(3);

        // Packet lock: later s_sel values are ignored
        send(2'd2, 8'h11, 1'b0, 2, 1'b1);
        send(2'd0, 8'h22, 1'b0, 2, 1'b1);
        send(2'd0, 8'h33, 1'b1, 2, 1'b1);
        send(2'd1, 8'h44, 1'b1, 1, 1'b1);
        idle(3);

        // Backpressure isolation
        m_ready[1] = 1'b0;
        send(2'd1, 8'hB1, 1'b1, 1, 1'b0);
        send(2'd0, 8'hD0, 1'b1, 0, 1'b1);
        s_valid = 1'b1; s_sel = 2'd1; s_data = 8'hB2; s_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_s_ready_low", {31'd0, s_ready}, 0);
        end
        @(posedge clk);
        #1;
        m_ready[1] = 1'b1;
        #1;
        chk("bp_s_ready_rise", {31'd0, s_ready}, 1);
        e.data = 8'hB2; e.last = 1'b1; e.acc = cyc + 1; e.chk_lat = 1'b1;
        exp_q[1].push_back(e);
        @(posedge clk);
        #1;
        send(2'd3, 8'hC3, 1'b1, 3, 1'b1);
        idle(3);

        // Drop on NCH=3: two-beat packet to channel 3
        t_valid = 1'b1; t_sel = 2'd3; t_last = 1'b0; t_data = 8'hE1;
        @(negedge clk);
        chk("drop_ready_b1", {31'd0, t_ready}, 1);
        @(posedge clk);
        #1;
        t_sel = 2'd0; t_last = 1'b1; t_data = 8'hE2;
        @(negedge clk);
        chk("drop_ready_b2", {31'd0, t_ready}, 1);
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        chk("drop_cnt_2", {24'd0, t_drop_cnt}, 2);
        t_valid = 1'b1; t_sel = 2'd3; t_last = 1'b1; t_data = 8'hE3;
        repeat (252) @(posedge clk);
        #1;
        chk("drop_cnt_254", {24'd0, t_drop_cnt}, 254);
        repeat (48) @(posedge clk);
        #1;
        t_valid = 1'b0;
        chk("drop_cnt_sat", {24'd0, t_drop_cnt}, 255);
        chk("drop_no_valid", {31'd0, saw_valid3}, 0);
        // After dropped packets, an in-range single beat still routes
        t_valid = 1'b1; t_sel = 2'd0; t_last = 1'b1; t_data = 8'h5A;
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        chk("nch3_route_valid", {29'd0, tm_valid}, 3'b001);
        chk("nch3_route_data", {24'd0, tm_data[7:0]}, 8'h5A);
        @(posedge clk);
        #1;

        // Reset in the middle of a packet to channel 2
        m_ready[2] = 1'b0;
        send(2'd2, 8'h51, 1'b0, -1, 1'b0);
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_m_valid", {28'd0, m_valid}, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_drop3", {24'd0, t_drop_cnt}, 0);
        rst = 1'b0;
        m_ready = 4'hF;
        send(2'd0, 8'h61, 1'b1, 0, 1'b1);
        idle(4);

        for (int k = 0; k < 4; k++) chk($sformatf("queue_empty_ch%0d", k), exp_q[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
